// File: rtl/cndm_msi_irq_sched.sv
// MSI interrupt scheduler for the UltraScale PCIe hard IP, physical function 0.
// Source requests are folded onto the enabled vector count. They are latched into
// pending bits and issued one at a time in round-robin order. Failed or timed-out
// vectors are retried after a backoff.
module cndm_msi_irq_sched #(
  parameter int unsigned IRQ_CNT     = 32,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned RETRY_DELAY = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_CNT-1:0] irq_req,
  input  logic [3:0]         cfg_interrupt_msi_enable,
  input  logic [11:0]        cfg_interrupt_msi_mmenable,
  output logic [31:0]        cfg_interrupt_msi_int,
  input  logic               cfg_interrupt_msi_sent,
  input  logic               cfg_interrupt_msi_fail,
  output logic [7:0]         cfg_interrupt_msi_function_number,
  output logic [2:0]         cfg_interrupt_msi_attr,
  output logic               cfg_interrupt_msi_tph_present,
  output logic [1:0]         cfg_interrupt_msi_tph_type,
  output logic [7:0]         cfg_interrupt_msi_tph_st_tag,
  output logic [31:0]        stat_pending,
  output logic               stat_sent,
  output logic               stat_fail
);

  localparam int unsigned CntMax = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int unsigned TimerW = $clog2(CntMax + 1);
  // Timeout fires on the cycle the timer would step onto TIMEOUT-1.
  localparam int unsigned TimeoutHitInt = (TIMEOUT >= 2) ? (TIMEOUT - 2) : 0;
  localparam logic [TimerW-1:0] TimeoutHit  = TimerW'(TimeoutHitInt);
  localparam logic [TimerW-1:0] BackoffLast = TimerW'(RETRY_DELAY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StBackoff} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pending_q, pending_d;
  logic [31:0]         msi_int_q, msi_int_d;
  logic [4:0]          sel_q, sel_d;
  logic [4:0]          rr_q, rr_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                stat_sent_q, stat_sent_d;
  logic                stat_fail_q, stat_fail_d;

  logic [4:0]          vec_mask;
  logic [31:0]         fold_req;
  logic [4:0]          pick;
  logic [4:0]          cand;
  logic                found;
  logic                unused_bits;

  assign unused_bits = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Vector count is 2^min(mmenable,5); mask is that count minus one.
  always_comb begin
    vec_mask = 5'd31;
    case (cfg_interrupt_msi_mmenable[2:0])
      3'd0:    vec_mask = 5'd0;
      3'd1:    vec_mask = 5'd1;
      3'd2:    vec_mask = 5'd3;
      3'd3:    vec_mask = 5'd7;
      3'd4:    vec_mask = 5'd15;
      default: vec_mask = 5'd31;
    endcase
  end

  // Fold sources onto vectors; sources sharing a vector coalesce.
  always_comb begin
    fold_req = '0;
    for (int i = 0; i < int'(IRQ_CNT); i++) begin
      if (irq_req[i]) begin
        fold_req[5'(i) & vec_mask] = 1'b1;
      end
    end
  end

  // First pending vector at or after the round-robin pointer, wrapping 31 -> 0.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < 32; i++) begin
      cand = rr_q + 5'(i);
      if (!found && pending_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    timer_d     = timer_q;
    msi_int_d   = '0;
    stat_sent_d = 1'b0;
    stat_fail_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_interrupt_msi_enable[0] && found) begin
          sel_d           = pick;
          pending_d[pick] = 1'b0;
          msi_int_d       = 32'd1 << pick;
          state_d         = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Fail takes priority over a simultaneous sent.
        if (cfg_interrupt_msi_fail) begin
          pending_d[sel_q] = 1'b1;
          stat_fail_d      = 1'b1;
          timer_d          = '0;
          state_d          = StBackoff;
        end else if (cfg_interrupt_msi_sent) begin
          stat_sent_d = 1'b1;
          rr_d        = sel_q + 5'd1;
          state_d     = StIdle;
        end else if (timer_q == TimeoutHit) begin
          pending_d[sel_q] = 1'b1;
          stat_fail_d      = 1'b1;
          timer_d          = '0;
          state_d          = StBackoff;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StBackoff: begin
        if (timer_q == BackoffLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // New requests OR in last so a request for the in-flight vector re-arms it.
    pending_d = pending_d | fold_req;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      msi_int_q   <= '0;
      sel_q       <= '0;
      rr_q        <= '0;
      timer_q     <= '0;
      stat_sent_q <= 1'b0;
      stat_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      msi_int_q   <= msi_int_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      timer_q     <= timer_d;
      stat_sent_q <= stat_sent_d;
      stat_fail_q <= stat_fail_d;
    end
  end

  assign cfg_interrupt_msi_int             = msi_int_q;
  assign cfg_interrupt_msi_function_number = 8'd0;
  assign cfg_interrupt_msi_attr            = 3'd0;
  assign cfg_interrupt_msi_tph_present     = 1'b0;
  assign cfg_interrupt_msi_tph_type        = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag      = 8'd0;
  assign stat_pending                      = pending_q;
  assign stat_sent                         = stat_sent_q;
  assign stat_fail                         = stat_fail_q;

endmodule
